// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the IF/OF/EX/MA/RW core.
// Tracks in-flight destination registers and drives stall, flush and bubble
// to resolve RAW interlocks, taken-branch refills and memory-busy freezes.
// Optional feature macro: HAZARD_FWD_EN (EX/MA bypass present, so only
// load-use dependencies interlock). Default build: full scoreboard interlock.
module hazard_ctrl #(
  parameter int unsigned DEPTH        = 3,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk2,
  input  logic        rst,
  input  logic        of_valid,
  input  logic [4:0]  of_rs1,
  input  logic [4:0]  of_rs2,
  input  logic        of_rs1_used,
  input  logic        of_rs2_used,
  input  logic [4:0]  of_rd,
  input  logic        of_wen,
  input  logic        of_is_load,
  input  logic        br_taken,
  input  logic        mem_busy,
  output logic        stall,
  output logic        flush,
  output logic        bubble,
  output logic [15:0] stall_cycles
);

  localparam int unsigned CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_FREEZE
  } state_e;

  // One in-flight producer: valid, destination register, is-a-load.
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } sb_entry_t;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  sb_entry_t       sb_q [DEPTH];
  sb_entry_t       sb_d [DEPTH];
  logic [15:0]     stall_cycles_q, stall_cycles_d;

  logic hit1, hit2, raw, issue;
  logic stall_c, flush_c, bubble_c;

  // Scoreboard lookup of both OF source registers; x0 never matches.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    hit1 = 1'b0;
    hit2 = 1'b0;
`ifdef HAZARD_FWD_EN
    // With bypassing only a load still in EX is too late to forward.
    hit1 = sb_q[0].v & sb_q[0].ld & (sb_q[0].rd == of_rs1) & (of_rs1 != 5'd0);
    hit2 = sb_q[0].v & sb_q[0].ld & (sb_q[0].rd == of_rs2) & (of_rs2 != 5'd0);
`else
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (sb_q[i].v && (sb_q[i].rd == of_rs1) && (of_rs1 != 5'd0)) hit1 = 1'b1;
      if (sb_q[i].v && (sb_q[i].rd == of_rs2) && (of_rs2 != 5'd0)) hit2 = 1'b1;
    end
`endif
  end

  // Control outputs; everything is forced low while reset is asserted.
  always_comb begin
    raw      = (state_q == ST_RUN) & of_valid &
               ((hit1 & of_rs1_used) | (hit2 & of_rs2_used));
    stall_c  = (state_q == ST_FREEZE) | mem_busy |
               ((state_q == ST_RUN) & raw & ~br_taken);
    flush_c  = (state_q == ST_FLUSH) |
               ((state_q == ST_RUN) & br_taken & ~mem_busy);
    bubble_c = ~mem_busy & (flush_c | ((state_q == ST_RUN) & raw));
    issue    = of_valid & ~stall_c & ~flush_c & (state_q == ST_RUN) & ~br_taken;
    stall        = ~rst & stall_c;
    flush        = ~rst & flush_c;
    bubble       = ~rst & bubble_c;
    stall_cycles = rst ? 16'h0000 : stall_cycles_q;
  end

  // Sequencer next state: memory busy beats branch, branch beats RAW.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          state_d = ST_FREEZE;
        end else if (br_taken) begin
          state_d = ST_FLUSH;
          cnt_d   = CW'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        // A busy memory only pauses the refill count; flush stays asserted.
        if (!mem_busy) begin
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_FREEZE: begin
        if (!mem_busy) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Scoreboard shift: new producer enters EX slot, oldest drops out of RW.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) sb_d[i] = sb_q[i];
    if (!mem_busy) begin
      sb_d[0] = issue ? '{v: of_wen & (of_rd != 5'd0), rd: of_rd, ld: of_is_load}
                      : sb_entry_t'('0);
      for (int i = 1; i < int'(DEPTH); i++) sb_d[i] = sb_q[i-1];
    end
  end

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_c && (stall_cycles_q != 16'hFFFF)) stall_cycles_d = stall_cycles_q + 16'd1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk2) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q        <= ST_RUN;
      cnt_q          <= '0;
      stall_cycles_q <= 16'h0000;
      // NOTE: the scoreboard is a handful of flops whose valid bits must clear, so it is reset like any register.
      for (int i = 0; i < int'(DEPTH); i++) sb_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
      for (int i = 0; i < int'(DEPTH); i++) sb_q[i] <= sb_d[i];
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Each cycle pushes the expected
// {stall,flush,bubble} into a queue as stimulus is driven and pops it when
// the combinational outputs are sampled mid-cycle.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wen;
    logic       ld;
    logic       br;
    logic       busy;
    logic       rst;
  } stim_t;

  logic        clk2 = 1'b0;
  logic        rst = 1'b1;
  logic        of_valid = 1'b0;
  logic [4:0]  of_rs1 = '0, of_rs2 = '0, of_rd = '0;
  logic        of_rs1_used = 1'b0, of_rs2_used = 1'b0;
  logic        of_wen = 1'b0, of_is_load = 1'b0;
  logic        br_taken = 1'b1, mem_busy = 1'b1;
  logic        stall, flush, bubble;
  logic [15:0] stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] exp_q[$];

  hazard_ctrl dut (
    .clk2(clk2), .rst(rst), .of_valid(of_valid),
    .of_rs1(of_rs1), .of_rs2(of_rs2),
    .of_rs1_used(of_rs1_used), .of_rs2_used(of_rs2_used),
    .of_rd(of_rd), .of_wen(of_wen), .of_is_load(of_is_load),
    .br_taken(br_taken), .mem_busy(mem_busy),
    .stall(stall), .flush(flush), .bubble(bubble),
    .stall_cycles(stall_cycles)
  );

  always #5 clk2 = ~clk2;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic stim_t st(int v, int rs1, int u1, int rs2, int u2, int rd,
                               int wen, int ld, int br, int busy, int r);
    stim_t s;
    s.v = v[0]; s.rs1 = rs1[4:0]; s.u1 = u1[0]; s.rs2 = rs2[4:0]; s.u2 = u2[0];
    s.rd = rd[4:0]; s.wen = wen[0]; s.ld = ld[0]; s.br = br[0]; s.busy = busy[0];
    s.rst = r[0];
    return s;
  endfunction

  // exp encoding: bit2 stall, bit1 flush, bit0 bubble
  task automatic cyc(input string tag, input stim_t s, input int e);
    logic [2:0] got;
    logic [2:0] want;
    @(negedge clk2);
    rst = s.rst; of_valid = s.v; of_rs1 = s.rs1; of_rs1_used = s.u1;
    of_rs2 = s.rs2; of_rs2_used = s.u2; of_rd = s.rd; of_wen = s.wen;
    of_is_load = s.ld; br_taken = s.br; mem_busy = s.busy;
    exp_q.push_back(e[2:0]);
    #2;
    got = {stall, flush, bubble};
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 16'd0, 16'd1);
    end else begin
      want = exp_q.pop_front();
      check({tag, ".stall"},  {15'd0, got[2]}, {15'd0, want[2]});
      check({tag, ".flush"},  {15'd0, got[1]}, {15'd0, want[1]});
      check({tag, ".bubble"}, {15'd0, got[0]}, {15'd0, want[0]});
    end
  endtask

  localparam int SB  = 5;  // stall + bubble
  localparam int FB  = 3;  // flush + bubble
  localparam int SF  = 6;  // stall + flush (busy during flush)
  localparam int S   = 4;  // stall only (freeze)

  initial begin
    stim_t idle;
    idle = st(0,0,0,0,0,0,0,0,0,0,0);

    // Reset with branch and busy asserted: everything quiet
    cyc("rst0", st(0,0,0,0,0,0,0,0,1,1,1), 0);
    check("rst0.cnt", stall_cycles, 16'd0);
    cyc("rst1", st(0,0,0,0,0,0,0,0,1,1,1), 0);
    check("rst1.cnt", stall_cycles, 16'd0);

    // ALU producer rd=5, consumer rs1=5
    cyc("t2.prod", st(1,0,0,0,0,5,1,0,0,0,0), 0);
    cyc("t2.dep1", st(1,5,1,0,0,6,0,0,0,0,0), FWD ? 0 : SB);
    cyc("t2.dep2", st(1,5,1,0,0,6,0,0,0,0,0), FWD ? 0 : SB);
    cyc("t2.dep3", st(1,5,1,0,0,6,0,0,0,0,0), FWD ? 0 : SB);
    cyc("t2.issue", st(1,5,1,0,0,6,0,0,0,0,0), 0);
    check("t2.cnt", stall_cycles, FWD ? 16'd0 : 16'd3);

    // Load producer rd=7, consumer rs2=7
    cyc("t3.load", st(1,0,0,0,0,7,1,1,0,0,0), 0);
    cyc("t3.dep1", st(1,0,0,7,1,0,0,0,0,0,0), SB);
    cyc("t3.dep2", st(1,0,0,7,1,0,0,0,0,0,0), FWD ? 0 : SB);
    cyc("t3.dep3", st(1,0,0,7,1,0,0,0,0,0,0), FWD ? 0 : SB);
    cyc("t3.issue", st(1,0,0,7,1,0,0,0,0,0,0), 0);
    check("t3.cnt", stall_cycles, FWD ? 16'd1 : 16'd6);
    for (int i = 0; i < 3; i++) cyc("drain", idle, 0);

    // Taken branch: flush in branch cycle plus FLUSH_CYCLES refill cycles, nothing issued
    cyc("t4.br",  st(1,0,0,0,0,9,1,0,1,0,0), FB);
    cyc("t4.fl1", st(1,0,0,0,0,9,1,0,0,0,0), FB);
    cyc("t4.fl2", st(1,0,0,0,0,9,1,0,0,0,0), FB);
    cyc("t4.run", st(1,9,1,0,0,0,0,0,0,0,0), 0);
    // Branch coinciding with a RAW hazard
    cyc("t4.prod", st(1,0,0,0,0,10,1,0,0,0,0), 0);
    cyc("t4.brraw", st(1,10,1,0,0,0,0,0,1,0,0), FB);
    cyc("t4.fl1b", idle, FB);
    cyc("t4.fl2b", idle, FB);
    cyc("t4.runb", idle, 0);

    // Memory busy during FLUSH: stall, count held, refill resumes after release
    cyc("t5.prod", st(1,0,0,0,0,11,1,0,0,0,0), 0);
    cyc("t5.br", st(0,0,0,0,0,0,0,0,1,0,0), FB);
    for (int i = 0; i < 4; i++) cyc("t5.busy", st(0,0,0,0,0,0,0,0,0,1,0), SF);
    cyc("t5.fr1", idle, FB);
    cyc("t5.fr2", idle, FB);
    cyc("t5.run", idle, 0);
    check("t5.cnt", stall_cycles, FWD ? 16'd5 : 16'd10);

    // Freeze from RUN keeps the scoreboard still
    cyc("fz.prod", st(1,0,0,0,0,12,1,0,0,0,0), 0);
    cyc("fz.b1", st(1,12,1,0,0,0,0,0,0,1,0), S);
    cyc("fz.b2", st(1,12,1,0,0,0,0,0,0,1,0), S);
    cyc("fz.b3", st(1,12,1,0,0,0,0,0,0,1,0), S);
    cyc("fz.rel", st(1,12,1,0,0,0,0,0,0,0,0), S);
    cyc("fz.dep1", st(1,12,1,0,0,0,0,0,0,0,0), FWD ? 0 : SB);
    cyc("fz.dep2", st(1,12,1,0,0,0,0,0,0,0,0), FWD ? 0 : SB);
    cyc("fz.dep3", st(1,12,1,0,0,0,0,0,0,0,0), 0);
    check("fz.cnt", stall_cycles, FWD ? 16'd9 : 16'd16);

    // Branch held across a freeze is ignored until RUN
    cyc("bh.busy", st(0,0,0,0,0,0,0,0,1,1,0), S);
    cyc("bh.rel",  st(0,0,0,0,0,0,0,0,1,0,0), S);
    cyc("bh.br",   st(0,0,0,0,0,0,0,0,1,0,0), FB);
    cyc("bh.fl1",  idle, FB);
    cyc("bh.fl2",  idle, FB);
    cyc("bh.run",  idle, 0);

    // Reset mid-FLUSH, mid-FREEZE, and with a live scoreboard entry
    cyc("rf.br",  st(0,0,0,0,0,0,0,0,1,0,0), FB);
    cyc("rf.fl",  idle, FB);
    cyc("rf.rst", st(0,0,0,0,0,0,0,0,0,0,1), 0);
    cyc("rf.run", idle, 0);
    cyc("rz.busy", st(0,0,0,0,0,0,0,0,0,1,0), S);
    cyc("rz.rst",  st(0,0,0,0,0,0,0,0,0,1,1), 0);
    cyc("rz.run",  idle, 0);
    cyc("rs.prod", st(1,0,0,0,0,13,1,0,0,0,0), 0);
    cyc("rs.rst",  st(0,0,0,0,0,0,0,0,0,0,1), 0);
    cyc("rs.dep",  st(1,13,1,0,0,0,0,0,0,0,0), 0);
    check("rs.cnt", stall_cycles, 16'd0);

    // x0 never hits; unused operand never hits
    cyc("x0.prod", st(1,0,0,0,0,0,1,1,0,0,0), 0);
    cyc("x0.dep",  st(1,0,1,0,1,0,0,0,0,0,0), 0);
    cyc("un.prod", st(1,0,0,0,0,14,1,1,0,0,0), 0);
    cyc("un.dep",  st(1,0,0,14,0,0,0,0,0,0,0), 0);

    // Saturation: 65534 stall cycles, then more stalls must not wrap
    cyc("sat.rst", st(0,0,0,0,0,0,0,0,0,0,1), 0);
    for (int i = 0; i < 65533; i++) begin
      @(negedge clk2);
      rst = 1'b0; of_valid = 1'b0; br_taken = 1'b0; mem_busy = 1'b1;
    end
    cyc("sat.rel",  idle, S);
    cyc("sat.prod", st(1,0,0,0,0,15,1,1,0,0,0), 0);
    check("sat.fffe", stall_cycles, 16'hFFFE);
    cyc("sat.dep1", st(1,15,1,0,0,0,0,0,0,0,0), SB);
    cyc("sat.dep2", st(1,15,1,0,0,0,0,0,0,0,0), FWD ? 0 : SB);
    cyc("sat.dep3", st(1,15,1,0,0,0,0,0,0,0,0), FWD ? 0 : SB);
    cyc("sat.busy", st(0,0,0,0,0,0,0,0,0,1,0), S);
    check("sat.ffff", stall_cycles, 16'hFFFF);
    cyc("sat.rel2", idle, S);
    check("sat.nowrap", stall_cycles, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
